// File: rtl/branch_redirect_ctrl.sv
// ID-stage branch/jump resolver: waits on forwarded operands, resolves
// BEQ/BNE/J/JR and issues a registered one-cycle PC redirect plus flush.
// Ports: clk, rst (async, active-high); ID decode flags id_valid/id_beq/
// id_bne/id_j/id_jr, opnd_ready, rs_val, rt_val, ext_imm, pc_plus_4, jidx;
// outputs stall_if_id (comb), flush_if_id, pc_redirect, redirect_pc, err.
// Optional macro BR_STATS_EN adds br_taken_cnt and br_resolved_cnt.
// PC_W must exceed 28 so the J-format region bits exist.
module branch_redirect_ctrl #(
  parameter int PC_W     = 32,
  parameter int WAIT_MAX = 15
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            id_valid,
  input  logic            id_beq,
  input  logic            id_bne,
  input  logic            id_j,
  input  logic            id_jr,
  input  logic            opnd_ready,
  input  logic [PC_W-1:0] rs_val,
  input  logic [PC_W-1:0] rt_val,
  input  logic [PC_W-1:0] ext_imm,
  input  logic [PC_W-1:0] pc_plus_4,
  input  logic [25:0]     jidx,
`ifdef BR_STATS_EN
  output logic [31:0]     br_taken_cnt,
  output logic [31:0]     br_resolved_cnt,
`endif
  output logic            stall_if_id,
  output logic            flush_if_id,
  output logic            pc_redirect,
  output logic [PC_W-1:0] redirect_pc,
  output logic            err
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT_OPND,
    REDIRECT
  } state_t;

  state_t          state;
  logic [7:0]      cnt;
  logic            ctl;
  logic            needs;
  logic            waiting;
  logic            resolve;
  logic            taken;
  logic [PC_W-1:0] target;
  logic [PC_W-1:0] bta;
  logic [PC_W-1:0] jta;

  assign ctl   = id_valid & (id_beq | id_bne | id_j | id_jr);
  // J is the only control op that does not read registers
  assign needs = id_jr | ~id_j;

  assign waiting = ctl & needs & ~opnd_ready;
  assign resolve = (state != REDIRECT) & ctl & ~waiting;

  assign stall_if_id = ~rst & (state != REDIRECT) & waiting;

  // shifting the full vector drops the top two offset bits
  assign bta = (ext_imm << 2) + pc_plus_4;
  assign jta = {pc_plus_4[PC_W-1:28], jidx, 2'b00};

  // several flags may be set at once: jr > j > bne > beq
  always_comb begin
    taken  = 1'b0;
    target = bta;
    priority case (1'b1)
      id_jr: begin
        taken  = 1'b1;
        target = rs_val;
      end
      id_j: begin
        taken  = 1'b1;
        target = jta;
      end
      id_bne: taken = (rs_val != rt_val);
      id_beq: taken = (rs_val == rt_val);
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= '0;
      flush_if_id <= 1'b0;
      pc_redirect <= 1'b0;
      redirect_pc <= '0;
      err         <= 1'b0;
    end else begin
      flush_if_id <= 1'b0;
      pc_redirect <= 1'b0;
      case (state)
        IDLE: begin
          if (waiting) begin
            state <= WAIT_OPND;
            cnt   <= 8'd1;
          end else if (ctl && taken) begin
            state       <= REDIRECT;
            pc_redirect <= 1'b1;
            flush_if_id <= 1'b1;
            redirect_pc <= target;
          end
        end
        WAIT_OPND: begin
          if (!ctl) begin
            state <= IDLE;
            cnt   <= '0;
          end else if (waiting) begin
            if (cnt != 8'hFF) cnt <= cnt + 8'd1;
            if (cnt == 8'(WAIT_MAX)) err <= 1'b1;
          end else begin
            cnt <= '0;
            if (taken) begin
              state       <= REDIRECT;
              pc_redirect <= 1'b1;
              flush_if_id <= 1'b1;
              redirect_pc <= target;
            end else begin
              state <= IDLE;
            end
          end
        end
        REDIRECT: state <= IDLE;
        default:  state <= IDLE;
      endcase
    end
  end

`ifdef BR_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_taken_cnt    <= '0;
      br_resolved_cnt <= '0;
    end else if (resolve) begin
      br_resolved_cnt <= br_resolved_cnt + 32'd1;
      if (taken) br_taken_cnt <= br_taken_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Directed bench for branch_redirect_ctrl.
// Immediate assertions count and report each miscompare.
module tb_branch_redirect_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid, id_beq, id_bne, id_j, id_jr;
  logic        opnd_ready;
  logic [31:0] rs_val, rt_val, ext_imm, pc_plus_4;
  logic [25:0] jidx;
  logic        stall_if_id, flush_if_id, pc_redirect, err;
  logic [31:0] redirect_pc;
`ifdef BR_STATS_EN
  logic [31:0] br_taken_cnt, br_resolved_cnt;
`endif

  int checks = 0;
  int errors = 0;

  branch_redirect_ctrl #(.PC_W(32), .WAIT_MAX(15)) dut (
    .clk(clk),
    .rst(rst),
    .id_valid(id_valid),
    .id_beq(id_beq),
    .id_bne(id_bne),
    .id_j(id_j),
    .id_jr(id_jr),
    .opnd_ready(opnd_ready),
    .rs_val(rs_val),
    .rt_val(rt_val),
    .ext_imm(ext_imm),
    .pc_plus_4(pc_plus_4),
    .jidx(jidx),
`ifdef BR_STATS_EN
    .br_taken_cnt(br_taken_cnt),
    .br_resolved_cnt(br_resolved_cnt),
`endif
    .stall_if_id(stall_if_id),
    .flush_if_id(flush_if_id),
    .pc_redirect(pc_redirect),
    .redirect_pc(redirect_pc),
    .err(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle_in();
    id_valid = 0; id_beq = 0; id_bne = 0; id_j = 0; id_jr = 0;
    opnd_ready = 0; rs_val = 0; rt_val = 0; ext_imm = 0;
    pc_plus_4 = 0; jidx = 0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    idle_in();
    rst = 1;
    tick();
    tick();
    chk("rst_stall", 32'(stall_if_id), 0);
    chk("rst_flush", 32'(flush_if_id), 0);
    chk("rst_redir", 32'(pc_redirect), 0);
    chk("rst_pc", redirect_pc, 0);
    chk("rst_err", 32'(err), 0);
    rst = 0;
    tick();

    // 1: BEQ taken
    id_valid = 1; id_beq = 1; rs_val = 5; rt_val = 5;
    ext_imm = 32'h4; pc_plus_4 = 32'h100; opnd_ready = 1;
    #1 chk("t1_stall", 32'(stall_if_id), 0);
    tick();
    chk("t1_redir", 32'(pc_redirect), 1);
    chk("t1_pc", redirect_pc, 32'h110);
    chk("t1_flush", 32'(flush_if_id), 1);
    idle_in();
    tick();
    chk("t1_redir_end", 32'(pc_redirect), 0);
    chk("t1_flush_end", 32'(flush_if_id), 0);
    chk("t1_pc_hold", redirect_pc, 32'h110);

    // 2: BNE not taken
    id_valid = 1; id_bne = 1; rs_val = 7; rt_val = 7;
    ext_imm = 32'h40; pc_plus_4 = 32'h300; opnd_ready = 1;
    #1 chk("t2_stall", 32'(stall_if_id), 0);
    tick();
    chk("t2_redir", 32'(pc_redirect), 0);
    chk("t2_pc_hold", redirect_pc, 32'h110);
    idle_in();

    // 3: BEQ waits 3 cycles for operands
    id_valid = 1; id_beq = 1; rs_val = 1; rt_val = 1;
    ext_imm = 32'h1; pc_plus_4 = 32'h200; opnd_ready = 0;
    for (int i = 0; i < 3; i++) begin
      #1 chk("t3_stall", 32'(stall_if_id), 1);
      tick();
      chk("t3_no_redir", 32'(pc_redirect), 0);
    end
    opnd_ready = 1;
    #1 chk("t3_stall_rdy", 32'(stall_if_id), 0);
    tick();
    chk("t3_redir", 32'(pc_redirect), 1);
    chk("t3_pc", redirect_pc, 32'h204);
    chk("t3_err", 32'(err), 0);
    idle_in();
    tick();

    // 4: J never waits
    id_valid = 1; id_j = 1; jidx = 26'h40;
    pc_plus_4 = 32'h8000_0000; opnd_ready = 0;
    #1 chk("t4j_stall", 32'(stall_if_id), 0);
    tick();
    chk("t4j_redir", 32'(pc_redirect), 1);
    chk("t4j_pc", redirect_pc, 32'h8000_0100);
    idle_in();
    tick();
    // JR outranks J and BEQ
    id_valid = 1; id_jr = 1; id_j = 1; id_beq = 1;
    rs_val = 32'h0040_0020; rt_val = 32'h1; jidx = 26'h3;
    pc_plus_4 = 32'h1000; opnd_ready = 1;
    tick();
    chk("t4jr_redir", 32'(pc_redirect), 1);
    chk("t4jr_pc", redirect_pc, 32'h0040_0020);
    // inputs ignored in the redirect cycle
    tick();
    chk("t4_redir_ign", 32'(pc_redirect), 0);
    idle_in();
    tick();

    // 5: target wrap and wait timeout
    id_valid = 1; id_beq = 1; rs_val = 9; rt_val = 9;
    ext_imm = 32'hFFFF_FFFF; pc_plus_4 = 32'h0; opnd_ready = 0;
    for (int i = 1; i <= 16; i++) begin
      #1 chk("t5_stall", 32'(stall_if_id), 1);
      tick();
      if (i == 14) chk("t5_err_early", 32'(err), 0);
    end
    chk("t5_err", 32'(err), 1);
    opnd_ready = 1;
    tick();
    chk("t5_redir", 32'(pc_redirect), 1);
    chk("t5_pc", redirect_pc, 32'hFFFF_FFFC);
    idle_in();
    tick();
    chk("t5_err_sticky", 32'(err), 1);
`ifdef BR_STATS_EN
    chk("stat_taken", br_taken_cnt, 5);
    chk("stat_resolved", br_resolved_cnt, 6);
`endif

    // 6: reset pulse while waiting
    id_valid = 1; id_bne = 1; rs_val = 1; rt_val = 2;
    ext_imm = 32'h8; pc_plus_4 = 32'h400; opnd_ready = 0;
    tick();
    tick();
    rst = 1;
    #1;
    chk("t6_stall", 32'(stall_if_id), 0);
    chk("t6_flush", 32'(flush_if_id), 0);
    chk("t6_redir", 32'(pc_redirect), 0);
    chk("t6_pc", redirect_pc, 0);
    chk("t6_err", 32'(err), 0);
`ifdef BR_STATS_EN
    chk("t6_stat_taken", br_taken_cnt, 0);
    chk("t6_stat_res", br_resolved_cnt, 0);
`endif
    #3 rst = 0;
    idle_in();
    tick();

    // id_valid drops while waiting: no redirect
    id_valid = 1; id_beq = 1; rs_val = 3; rt_val = 3;
    ext_imm = 32'h10; pc_plus_4 = 32'h500; opnd_ready = 0;
    tick();
    tick();
    id_valid = 0;
    #1 chk("t7_stall", 32'(stall_if_id), 0);
    tick();
    chk("t7_redir", 32'(pc_redirect), 0);
    // back in IDLE: a taken BNE resolves straight away
    idle_in();
    id_valid = 1; id_bne = 1; rs_val = 1; rt_val = 2;
    ext_imm = 32'h2; pc_plus_4 = 32'h600; opnd_ready = 1;
    tick();
    chk("t7_bne_redir", 32'(pc_redirect), 1);
    chk("t7_bne_pc", redirect_pc, 32'h608);
    idle_in();
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
